dma_arbiter: RTL and testbench

Arbitrates the single external wishbone memory port between three requesters: the CPU's single-word accesses, video DMA 4-word bursts and sound DMA 4-word bursts. It sits between the MEMC address translation/DMA pointer logic and the SDRAM controller. It sequences each transaction, generates burst cycle-type tags and addresses, and routes the memory acknowledge back to the owning requester. Bursts are never interrupted, and CPU starvation by video is bounded.

---
 rtl/dma_arbiter_if.sv | 40 ++++
 rtl/dma_arbiter.sv | 138 +++++++++++++
 tb/tb_dma_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_arbiter_if.sv
// Bus bundle between the DMA arbiter, its three requesters and the external memory port.
// The master modport is the arbiter's view; slave is the environment's view.
interface dma_arbiter_if;
    logic        cpu_cyc;
    logic        cpu_stb;
    logic        cpu_we;
    logic [3:0]  cpu_sel;
    logic [21:0] cpu_addr;
    logic        cpu_ack;

    logic        vid_req;
    logic [21:0] vid_addr;
    logic        vid_ack;

    logic        snd_req;
    logic [21:0] snd_addr;
    logic        snd_ack;

    logic        mem_cyc_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [2:0]  mem_cti_o;
    logic [21:0] mem_addr_o;
    logic        mem_ack_i;

    modport master (
        input  cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_addr,
        input  vid_req, vid_addr, snd_req, snd_addr, mem_ack_i,
        output cpu_ack, vid_ack, snd_ack,
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_addr_o
    );

    modport slave (
        output cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_addr,
        output vid_req, vid_addr, snd_req, snd_addr, mem_ack_i,
        input  cpu_ack, vid_ack, snd_ack,
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_addr_o
    );
endinterface

// File: rtl/dma_arbiter.sv
// Shares one wishbone memory port between CPU single-word accesses and video/sound
// 4-beat DMA bursts; bursts are never interrupted and CPU starvation by video is bounded.
module dma_arbiter (
    input  logic          clkcpu,
    input  logic          rst_i,
    dma_arbiter_if.master bus,
    output logic          cpu_owed
);

    typedef enum logic [1:0] {StIdle, StCpu, StVid, StSnd} state_e;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  cti_q, cti_d;
    logic [21:0] addr_q, addr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        owed_q, owed_d;
    logic        cpu_req;
    logic        go_idle;
    logic [1:0]  cnt_inc;

    always_comb begin
        cpu_req = bus.cpu_cyc & bus.cpu_stb;
        cnt_inc = cnt_q + 2'd1;
        go_idle = 1'b0;
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cti_d   = cti_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        owed_d  = owed_q;

        case (state_q)
            StIdle: begin
                if (bus.snd_req) begin
                    state_d = StSnd;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    cti_d   = CtiIncr;
                    cnt_d   = 2'd0;
                    addr_d  = {bus.snd_addr[21:2], 2'b00};
                end else if (bus.vid_req && !(owed_q && cpu_req)) begin
                    state_d = StVid;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    cti_d   = CtiIncr;
                    cnt_d   = 2'd0;
                    addr_d  = {bus.vid_addr[21:2], 2'b00};
                end else if (cpu_req) begin
                    state_d = StCpu;
                    cyc_d   = 1'b1;
                    we_d    = bus.cpu_we;
                    sel_d   = bus.cpu_sel;
                    cti_d   = CtiClassic;
                    addr_d  = bus.cpu_addr;
                end
            end
            StCpu: begin
                // Not abortable: a dropped cyc still waits for the memory ack.
                if (bus.mem_ack_i) begin
                    go_idle = 1'b1;
                    owed_d  = 1'b0;
                end
            end
            StVid, StSnd: begin
                if (bus.mem_ack_i) begin
                    if (cnt_q == 2'd3) begin
                        go_idle = 1'b1;
                        if (cpu_req) begin
                            owed_d = 1'b1;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        addr_d = {addr_q[21:2], cnt_inc};
                        cti_d  = (cnt_inc == 2'd3) ? CtiEnd : CtiIncr;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'h0;
            cti_d   = CtiClassic;
            addr_d  = 22'h0;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            cti_q   <= 3'b000;
            addr_q  <= 22'h0;
            cnt_q   <= 2'd0;
            owed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cti_q   <= cti_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            owed_q  <= owed_d;
        end
    end

    assign bus.mem_cyc_o  = cyc_q;
    assign bus.mem_stb_o  = cyc_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_sel_o  = sel_q;
    assign bus.mem_cti_o  = cti_q;
    assign bus.mem_addr_o = addr_q;
    assign cpu_owed       = owed_q;

    // Acks are forwarded with no latency, but never during a reset cycle.
    assign bus.cpu_ack = bus.mem_ack_i & ~rst_i & (state_q == StCpu);
    assign bus.vid_ack = bus.mem_ack_i & ~rst_i & (state_q == StVid);
    assign bus.snd_ack = bus.mem_ack_i & ~rst_i & (state_q == StSnd);

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed per-cycle vector bench for dma_arbiter plus a CPU wait-bound sequence
// under continuous video traffic.
module tb_dma_arbiter;

    typedef struct packed {
        logic        rst;
        logic        creq;
        logic        we;
        logic [3:0]  sel;
        logic [21:0] ca;
        logic        vreq;
        logic [21:0] va;
        logic        sreq;
        logic [21:0] sa;
        logic        ack;
    } in_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [21:0] addr;
        logic        cack;
        logic        vack;
        logic        sack;
        logic        owed;
    } out_t;

    typedef struct {
        string tag;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clkcpu;
    logic rst_i;
    logic cpu_owed;
    int   tests;
    int   fails;
    vec_t tbl[$];

    dma_arbiter_if bus ();

    dma_arbiter dut (
        .clkcpu   (clkcpu),
        .rst_i    (rst_i),
        .bus      (bus.master),
        .cpu_owed (cpu_owed)
    );

    initial clkcpu = 1'b0;
    always #5 clkcpu = ~clkcpu;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t vi(logic rst, logic creq, logic we, logic [3:0] sel,
                               logic [21:0] ca, logic vreq, logic [21:0] va,
                               logic sreq, logic [21:0] sa, logic ack);
        in_t r;
        r = '{rst, creq, we, sel, ca, vreq, va, sreq, sa, ack};
        return r;
    endfunction

    function automatic out_t vo(logic cyc, logic we, logic [3:0] sel, logic [2:0] cti,
                                logic [21:0] a, logic cack, logic vack, logic sack,
                                logic owed);
        out_t r;
        r = '{cyc, cyc, we, sel, cti, a, cack, vack, sack, owed};
        return r;
    endfunction

    function automatic out_t idle(logic owed);
        return vo(1'b0, 1'b0, 4'h0, 3'b000, 22'h0, 1'b0, 1'b0, 1'b0, owed);
    endfunction

    task automatic add(input string tag, input in_t i, input out_t o);
        vec_t v;
        v.tag = tag;
        v.i   = i;
        v.o   = o;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        out_t act;
        rst_i        = v.i.rst;
        bus.cpu_cyc  = v.i.creq;
        bus.cpu_stb  = v.i.creq;
        bus.cpu_we   = v.i.we;
        bus.cpu_sel  = v.i.sel;
        bus.cpu_addr = v.i.ca;
        bus.vid_req  = v.i.vreq;
        bus.vid_addr = v.i.va;
        bus.snd_req  = v.i.sreq;
        bus.snd_addr = v.i.sa;
        bus.mem_ack_i = v.i.ack;
        #2;
        act = {bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.mem_sel_o, bus.mem_cti_o,
               bus.mem_addr_o, bus.cpu_ack, bus.vid_ack, bus.snd_ack, cpu_owed};
        tests++;
        if (act !== v.o) begin
            fails++;
            $display("FAIL %s vec %0d: got %h want %h", v.tag, idx, act, v.o);
        end
        @(negedge clkcpu);
    endtask

    initial begin
        int   n;
        logic got;
        tests = 0;
        fails = 0;
        rst_i = 1'b1;
        bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_sel = 4'h0; bus.cpu_addr = 22'h0;
        bus.vid_req = 1'b0; bus.vid_addr = 22'h0;
        bus.snd_req = 1'b0; bus.snd_addr = 22'h0;
        bus.mem_ack_i = 1'b0;

        // Reset state; a stray ack is ignored.
        add("reset", vi(1, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 1), idle(0));

        // CPU read with a 2-cycle memory wait.
        add("cpu_rd", vi(0, 1, 0, 4'hF, 22'h048D, 0, 22'h0, 0, 22'h0, 0), idle(0));
        add("cpu_rd", vi(0, 1, 0, 4'hF, 22'h048D, 0, 22'h0, 0, 22'h0, 0),
            vo(1, 0, 4'hF, 3'b000, 22'h048D, 0, 0, 0, 0));
        add("cpu_rd", vi(0, 1, 0, 4'hF, 22'h048D, 0, 22'h0, 0, 22'h0, 0),
            vo(1, 0, 4'hF, 3'b000, 22'h048D, 0, 0, 0, 0));
        add("cpu_rd", vi(0, 1, 0, 4'hF, 22'h048D, 0, 22'h0, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b000, 22'h048D, 1, 0, 0, 0));
        add("cpu_rd", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 0), idle(0));

        // Video burst from base 0x10007, one wait state, req dropped mid-burst.
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 1, 22'h10007, 0, 22'h0, 0), idle(0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h10007, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h10004, 0, 1, 0, 0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h10007, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h10005, 0, 1, 0, 0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h10007, 0, 22'h0, 0),
            vo(1, 0, 4'hF, 3'b010, 22'h10006, 0, 0, 0, 0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h10007, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h10006, 0, 1, 0, 0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h10007, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b111, 22'h10007, 0, 1, 0, 0));
        add("vid", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 1), idle(0));

        // All three request together: SND, then CPU (owed), then VID.
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 1, 22'h2000A, 0), idle(0));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h20008, 0, 0, 1, 0));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h20009, 0, 0, 1, 0));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h2000A, 0, 0, 1, 0));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 1),
            vo(1, 0, 4'hF, 3'b111, 22'h2000B, 0, 0, 1, 0));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 0), idle(1));
        add("all3", vi(0, 1, 1, 4'h3, 22'h00ABC, 1, 22'h30000, 0, 22'h2000A, 1),
            vo(1, 1, 4'h3, 3'b000, 22'h00ABC, 1, 0, 0, 1));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 1, 22'h30000, 0, 22'h0, 0), idle(0));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h30000, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h30000, 0, 1, 0, 0));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h30000, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h30001, 0, 1, 0, 0));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h30000, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h30002, 0, 1, 0, 0));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h30000, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b111, 22'h30003, 0, 1, 0, 0));
        add("all3", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 0), idle(0));

        // CPU drops cyc inside its transaction; it still completes on mem ack.
        add("cpu_drop", vi(0, 1, 1, 4'h1, 22'h3FFFFF, 0, 22'h0, 0, 22'h0, 0), idle(0));
        add("cpu_drop", vi(0, 0, 1, 4'h1, 22'h3FFFFF, 0, 22'h0, 0, 22'h0, 0),
            vo(1, 1, 4'h1, 3'b000, 22'h3FFFFF, 0, 0, 0, 0));
        add("cpu_drop", vi(0, 0, 1, 4'h1, 22'h3FFFFF, 0, 22'h0, 0, 22'h0, 1),
            vo(1, 1, 4'h1, 3'b000, 22'h3FFFFF, 1, 0, 0, 0));
        add("cpu_drop", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 0), idle(0));

        // Reset during beat 2 of a sound burst, then a normal CPU access.
        add("snd_rst", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 1, 22'h0FFF3, 0), idle(0));
        add("snd_rst", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0FFF3, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h0FFF0, 0, 0, 1, 0));
        add("snd_rst", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0FFF3, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h0FFF1, 0, 0, 1, 0));
        add("snd_rst", vi(1, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0FFF3, 1),
            vo(1, 0, 4'hF, 3'b010, 22'h0FFF2, 0, 0, 0, 0));
        add("snd_rst", vi(0, 1, 0, 4'hF, 22'h00005, 0, 22'h0, 0, 22'h0, 0), idle(0));
        add("snd_rst", vi(0, 1, 0, 4'hF, 22'h00005, 0, 22'h0, 0, 22'h0, 1),
            vo(1, 0, 4'hF, 3'b000, 22'h00005, 1, 0, 0, 0));
        add("snd_rst", vi(0, 0, 0, 4'h0, 22'h0, 0, 22'h0, 0, 22'h0, 0), idle(0));

        repeat (2) @(negedge clkcpu);
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], k);
        end

        // Continuous video with a CPU request raised as each burst is granted:
        // idle, 4 beats, idle, CPU ack -> ack on the 7th cycle every round.
        rst_i = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 22'h00080;
        bus.cpu_cyc  = 1'b1;
        bus.cpu_stb  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_sel  = 4'hF;
        bus.cpu_addr = 22'h00222;
        bus.mem_ack_i = bus.mem_cyc_o;
        for (int r = 0; r < 3; r++) begin
            n   = 1;
            got = 1'b0;
            while (n <= 20 && !got) begin
                #2;
                if (bus.cpu_ack === 1'b1) begin
                    got = 1'b1;
                end else begin
                    @(negedge clkcpu);
                    bus.mem_ack_i = bus.mem_cyc_o;
                    n++;
                end
            end
            tests++;
            if (!got || n != 7) begin
                fails++;
                $display("FAIL cpu_wait round %0d: ack seen=%0d after %0d cycles, want 7",
                         r, got, n);
            end
            if (r == 2) begin
                bus.vid_req = 1'b0;
                bus.cpu_cyc = 1'b0;
                bus.cpu_stb = 1'b0;
            end
            @(negedge clkcpu);
            bus.mem_ack_i = bus.mem_cyc_o;
        end
        #2;
        tests++;
        if (bus.mem_cyc_o !== 1'b0 || cpu_owed !== 1'b0) begin
            fails++;
            $display("FAIL cpu_wait_end: cyc=%b owed=%b, want cyc=0 owed=0",
                     bus.mem_cyc_o, cpu_owed);
        end
        @(negedge clkcpu);
        bus.mem_ack_i = 1'b0;
        #2;
        tests++;
        if (bus.mem_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: cyc=%b, want 0", bus.mem_cyc_o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
